// File: rtl/aiva_pkg.sv
// Shared Aiva definitions: mnemonic constants, whitespace bytes and the
// opcode_fetch state encoding. The accumulator imports the same constants.
package aiva_pkg;

    // Three-character ASCII mnemonics, first character in the top byte.
    localparam logic [23:0] MN_LDA = 24'h4C4441;
    localparam logic [23:0] MN_INC = 24'h494E43;
    localparam logic [23:0] MN_DEC = 24'h444543;

    // Bytes skipped while waiting for the first mnemonic character.
    localparam logic [7:0] WS_SPACE = 8'h20;
    localparam logic [7:0] WS_LF    = 8'h0A;
    localparam logic [7:0] WS_CR    = 8'h0D;

    // opcode_fetch state encoding.
    localparam logic [2:0] ST_C0    = 3'd0;
    localparam logic [2:0] ST_C1    = 3'd1;
    localparam logic [2:0] ST_C2    = 3'd2;
    localparam logic [2:0] ST_OPND  = 3'd3;
    localparam logic [2:0] ST_ISSUE = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;

    function automatic logic is_ws(input logic [7:0] b);
        return (b == WS_SPACE) || (b == WS_LF) || (b == WS_CR);
    endfunction

endpackage

// File: rtl/opcode_fetch.sv
// Assembles three ASCII characters into a 24-bit opcode (plus one operand
// byte for LDA) and issues a single-cycle command to the accumulator.
module opcode_fetch
    import aiva_pkg::*;
#(
    parameter logic [23:0] LDA = MN_LDA,
    parameter logic [23:0] INC = MN_INC,
    parameter logic [23:0] DEC = MN_DEC
) (
    input  logic        clk,
    input  logic        fetch_rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] opcode,
    output logic [7:0]  acc_data_in,
    output logic        op_rdy,
    output logic        acc_en,
    output logic        err
);

    logic [2:0]  state_q, state_d;
    logic [23:0] shadow_q, shadow_d;
    logic [7:0]  operand_q, operand_d;
    logic [23:0] opcode_q, opcode_d;
    logic [7:0]  data_q, data_d;
    logic        ready_q, ready_d;
    logic        op_rdy_q, op_rdy_d;
    logic        err_q, err_d;
    logic        accept;
    logic [23:0] word;

    assign accept = in_valid && ready_q;
    // Candidate mnemonic if the current byte is the third character.
    assign word   = {shadow_q[23:8], in_byte};

    // Next-state, character collection and mnemonic match.
    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        operand_d = operand_q;
        unique case (state_q)
            ST_C0: begin
                if (accept && !is_ws(in_byte)) begin
                    shadow_d[23:16] = in_byte;
                    state_d         = ST_C1;
                end
            end
            ST_C1: begin
                if (accept) begin
                    shadow_d[15:8] = in_byte;
                    state_d        = ST_C2;
                end
            end
            ST_C2: begin
                if (accept) begin
                    shadow_d[7:0] = in_byte;
                    if (word == LDA) begin
                        state_d = ST_OPND;
                    end else if (word == INC || word == DEC) begin
                        operand_d = 8'h00;
                        state_d   = ST_ISSUE;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_OPND: begin
                if (accept) begin
                    operand_d = in_byte;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_C0;
            ST_ERROR: begin
                // Drop the unrecognised mnemonic.
                shadow_d = 24'h0;
                state_d  = ST_C0;
            end
            default: state_d = ST_C0;
        endcase
    end

    // Output registers decoded from the next state so strobes and ready
    // line up with the state they describe.
    always_comb begin
        opcode_d = opcode_q;
        data_d   = data_q;
        if (state_d == ST_ISSUE && state_q != ST_ISSUE) begin
            opcode_d = shadow_d;
            data_d   = operand_d;
        end
        ready_d  = (state_d != ST_ISSUE) && (state_d != ST_ERROR);
        op_rdy_d = (state_d == ST_ISSUE);
        err_d    = (state_d == ST_ERROR);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge fetch_rst_n) begin
        if (!fetch_rst_n) begin
            state_q   <= ST_C0;
            shadow_q  <= 24'h0;
            operand_q <= 8'h0;
            opcode_q  <= 24'h0;
            data_q    <= 8'h0;
            ready_q   <= 1'b1;
            op_rdy_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            operand_q <= operand_d;
            opcode_q  <= opcode_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            op_rdy_q  <= op_rdy_d;
            err_q     <= err_d;
        end
    end

    assign in_ready    = ready_q;
    assign opcode      = opcode_q;
    assign acc_data_in = data_q;
    assign op_rdy      = op_rdy_q;
    assign acc_en      = op_rdy_q;
    assign err         = err_q;

endmodule

// File: tb/tb_opcode_fetch.sv
// Bench for opcode_fetch: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then random byte streams.
module tb_opcode_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] opcode;
    logic [7:0]  acc_data_in;
    logic        op_rdy;
    logic        acc_en;
    logic        err;

    int tests = 0;
    int fails = 0;

    opcode_fetch dut (
        .clk         (clk),
        .fetch_rst_n (rst_n),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .acc_data_in (acc_data_in),
        .op_rdy      (op_rdy),
        .acc_en      (acc_en),
        .err         (err)
    );

    always #5 clk = ~clk;

    localparam logic [23:0] K_LDA = 24'h4C4441;
    localparam logic [23:0] K_INC = 24'h494E43;
    localparam logic [23:0] K_DEC = 24'h444543;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted non-leading-whitespace bytes are queued;
    // a complete command produces one strobe cycle with ready low.
    logic [7:0]  q[$];
    logic        e_ready, e_op, e_err;
    logic [23:0] e_opcode;
    logic [7:0]  e_data;

    function automatic logic ws(input logic [7:0] b);
        return b == 8'h20 || b == 8'h0A || b == 8'h0D;
    endfunction

    task automatic model_reset();
        q.delete();
        e_ready = 1'b1; e_op = 1'b0; e_err = 1'b0;
        e_opcode = 24'h0; e_data = 8'h0;
    endtask

    task automatic model_step();
        logic [23:0] w;
        if (in_valid && e_ready) begin
            if (!(q.size() == 0 && ws(in_byte))) q.push_back(in_byte);
        end
        e_op = 1'b0; e_err = 1'b0; e_ready = 1'b1;
        if (q.size() == 3) begin
            w = {q[0], q[1], q[2]};
            if (w == K_INC || w == K_DEC) begin
                e_op = 1'b1; e_ready = 1'b0; e_opcode = w; e_data = 8'h00;
                q.delete();
            end else if (w != K_LDA) begin
                e_err = 1'b1; e_ready = 1'b0;
                q.delete();
            end
        end else if (q.size() == 4) begin
            e_op = 1'b1; e_ready = 1'b0;
            e_opcode = {q[0], q[1], q[2]}; e_data = q[3];
            q.delete();
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare plus strobe bookkeeping for directed checks.
    int          n_issue = 0;
    int          n_err = 0;
    logic [23:0] last_op = 24'h0;
    logic [7:0]  last_data = 8'h0;

    initial begin
        forever begin
            @(negedge clk);
            check("in_ready", {31'b0, in_ready}, {31'b0, e_ready});
            check("op_rdy", {31'b0, op_rdy}, {31'b0, e_op});
            check("acc_en", {31'b0, acc_en}, {31'b0, e_op});
            check("err", {31'b0, err}, {31'b0, e_err});
            check("opcode", {8'b0, opcode}, {8'b0, e_opcode});
            check("acc_data_in", {24'b0, acc_data_in}, {24'b0, e_data});
            if (op_rdy) begin
                n_issue++; last_op = opcode; last_data = acc_data_in;
            end
            if (err) n_err++;
        end
    end

    // Offer one byte from a negedge; returns at the negedge after acceptance.
    task automatic send(input logic [7:0] b);
        logic was_ready;
        int   budget = 50;
        in_valid = 1'b1;
        in_byte  = b;
        do begin
            was_ready = in_ready;
            @(negedge clk);
            budget--;
        end while (!was_ready && budget > 0);
        if (!was_ready) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic send3(input logic [23:0] w);
        send(w[23:16]); send(w[15:8]); send(w[7:0]);
    endtask

    int i0, e0;

    initial begin
        #2;
        @(negedge clk);
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        check("rst_opcode", {8'b0, opcode}, 32'd0);
        check("rst_op_rdy", {31'b0, op_rdy}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // INC back-to-back.
        i0 = n_issue;
        send3(K_INC);
        check("inc_strobe_now", {31'b0, op_rdy}, 32'd1);
        check("inc_ready_low", {31'b0, in_ready}, 32'd0);
        idle(3);
        check("inc_count", n_issue - i0, 32'd1);
        check("inc_opcode", {8'b0, last_op}, 32'h494E43);
        check("inc_data", {24'b0, last_data}, 32'h00);

        // LDA with a space operand.
        i0 = n_issue;
        send3(K_LDA); send(8'h20);
        idle(3);
        check("lda_count", n_issue - i0, 32'd1);
        check("lda_opcode", {8'b0, last_op}, 32'h4C4441);
        check("lda_data", {24'b0, last_data}, 32'h20);

        // Leading whitespace then DEC.
        i0 = n_issue;
        send(8'h0A); send(8'h20); send3(K_DEC);
        idle(3);
        check("dec_count", n_issue - i0, 32'd1);
        check("dec_opcode", {8'b0, last_op}, 32'h444543);

        // Unknown mnemonic, then INC.
        i0 = n_issue; e0 = n_err;
        send3(24'h58595A);
        idle(3);
        check("xyz_err", n_err - e0, 32'd1);
        check("xyz_no_issue", n_issue - i0, 32'd0);
        check("xyz_opcode_kept", {8'b0, opcode}, 32'h444543);
        send3(K_INC);
        idle(3);
        check("post_err_issue", n_issue - i0, 32'd1);
        check("post_err_opcode", {8'b0, last_op}, 32'h494E43);

        // Reset mid-mnemonic.
        i0 = n_issue;
        send(8'h4C); send(8'h44);
        idle(0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_opcode", {8'b0, opcode}, 32'd0);
        check("midrst_data", {24'b0, acc_data_in}, 32'd0);
        check("midrst_ready", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        send3(K_DEC);
        idle(3);
        check("midrst_count", n_issue - i0, 32'd1);
        check("midrst_opcode_dec", {8'b0, last_op}, 32'h444543);

        // in_valid toggling.
        i0 = n_issue;
        send(8'h4C); idle(1); send(8'h44); idle(1); send(8'h41); idle(1); send(8'h7F);
        idle(3);
        check("toggle_count", n_issue - i0, 32'd1);
        check("toggle_opcode", {8'b0, last_op}, 32'h4C4441);
        check("toggle_data", {24'b0, last_data}, 32'h7F);

        // Random streams of valid, junk and whitespace commands with gaps.
        for (int k = 0; k < 250; k++) begin
            int sel = int'($urandom_range(0, 5));
            logic [23:0] w;
            case (sel)
                0: w = K_LDA;
                1: w = K_INC;
                2: w = K_DEC;
                3: w = 24'($urandom);
                4: w = {K_LDA[23:8], 8'($urandom)};
                default: w = {8'h20, 8'h0D, 8'h0A};
            endcase
            for (int b = 2; b >= 0; b--) begin
                send(w[b*8 +: 8]);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
            end
            if (w == K_LDA) send(8'($urandom));
            if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(0, 2)));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/opcode_fetch.md
# opcode_fetch

Front-end stage of the Aiva datapath, directly upstream of the accumulator. It receives an ASCII instruction stream one byte at a time over a valid/ready handshake and assembles three-character mnemonics into a 24-bit opcode. For LDA it also captures one raw operand byte. It then issues opcode, operand, `op_rdy` and `acc_en` to the accumulator as a single-cycle command and flags unknown mnemonics.

## Interface
Parameters:
- `LDA`, default 24'h4C4441 ("LDA"): load mnemonic; takes one operand byte.
- `INC`, default 24'h494E43 ("INC"): increment mnemonic; no operand.
- `DEC`, default 24'h444543 ("DEC"): decrement mnemonic; no operand.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk` input 1: the single clock; all state updates on the rising edge.
  - `fetch_rst_n` input 1: asynchronous, active-low reset.
- `in_byte` input 8: incoming ASCII or operand byte.
- `in_valid` input 1: `in_byte` is valid.
- `in_ready` output 1: the block accepts a byte this cycle.
- `opcode` output 24: assembled mnemonic, first character in [23:16]; drives the accumulator `opcode`.
- `acc_data_in` output 8: operand for LDA, 8'h00 for INC/DEC.
- `op_rdy` output 1: one-cycle issue strobe.
- `acc_en` output 1: accumulator enable; identical to `op_rdy`.
- `err` output 1: one-cycle pulse on an unrecognised mnemonic.

## Operation
- A byte is accepted when `in_valid && in_ready` at a rising edge.
- States: C0, C1, C2, OPND, ISSUE, ERROR. Encoding is in the package.
- C0: waiting for the first character.
  - Bytes 8'h20, 8'h0A and 8'h0D are accepted and discarded; the state stays C0.
  - Any other byte goes to shadow[23:16], then the state moves to C1.
- C1: accepted byte goes to shadow[15:8], then C2. Whitespace is not skipped.
- C2: accepted byte goes to shadow[7:0]. The full 24-bit value {shadow[23:8], in_byte} is compared with the mnemonic parameters:
  - LDA: move to OPND.
  - INC or DEC: operand register cleared to 8'h00, then ISSUE.
  - anything else: ERROR.
- OPND: the accepted byte, any value including whitespace, goes to the operand register, then ISSUE.
- ISSUE (one cycle):
  - `op_rdy` = `acc_en` = 1.
  - `opcode` shows the shadow value and `acc_data_in` shows the operand.
  - Next state is C0.
- ERROR (one cycle):
  - `err` = 1.
  - The shadow is discarded, `opcode` and `acc_data_in` keep their previous values, and no strobe is raised.
  - Next state is C0.
- `opcode` and `acc_data_in` are registered. They update only on entry to ISSUE and stay stable until the next ISSUE.
- `in_valid` low in any collecting state: the state holds indefinitely; there is no timeout.

## Timing
- Reset values: state C0, `in_ready` 1, `opcode` 24'h0, `acc_data_in` 8'h0, `op_rdy` 0, `acc_en` 0, `err` 0, shadow and operand registers 0.
- `in_ready` is 1 in C0, C1, C2 and OPND, and 0 in ISSUE and ERROR. It is a registered, state-decoded signal with no combinational path from `in_valid`.
- Latency: final byte accepted at edge N; `op_rdy` (or `err`) is high from edge N until edge N+1.
- Minimum command period with continuous `in_valid`:
  - INC/DEC: 4 cycles.
  - LDA: 5 cycles.
- Outputs are valid in the strobe cycle, so the accumulator samples them at the edge that ends it.
- Reset asserted mid-command: the partial mnemonic is lost and all outputs go to their reset values immediately. Collection restarts in C0 on the first edge after deassertion.
- A byte offered during ISSUE or ERROR is not accepted. The source must hold it, per the handshake.

## Structure
- A shared package (`aiva_pkg`, also used by the accumulator) holds:
  - the LDA/INC/DEC mnemonic constants,
  - the whitespace byte constants,
  - the state encoding.
- The accumulator takes its mnemonic constants from the same package, so there is a single source of truth.
- Single module, no sub-module. Mnemonic matching is a small combinational compare inside the block.

## Test plan
- Reset, then bytes "INC" with `in_valid` continuous → `op_rdy`/`acc_en` high for one cycle, 1 cycle after the 'C' is accepted. `opcode` 24'h494E43, `acc_data_in` 8'h00, `in_ready` low in that cycle.
- Bytes "LDA", 8'h20 → `opcode` 24'h4C4441, `acc_data_in` 8'h20. The space is taken as the operand, not skipped.
- Bytes 8'h0A, 8'h20, "DEC" → leading whitespace dropped; one issue with `opcode` 24'h444543.
- Bytes "XYZ" → `err` high for one cycle, no `op_rdy`, `opcode` keeps its previous value. A following "INC" issues normally.
- "LD", reset pulsed low for one cycle, then "DEC" → all outputs zero during reset; exactly one issue, of DEC.
- "LDA", 8'h7F with `in_valid` toggling every other cycle → no bytes lost or duplicated; a single issue with `acc_data_in` 8'h7F.
